// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Optional feature macro: RR_MUX_ARBITER_LOCK_EN (packet lock on in_last).
package rr_mux_arbiter_pkg;

  localparam int unsigned N_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage : rr_mux_arbiter_pkg

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker: finds the first set request bit,
// searching upward from (ptr+1) and wrapping 3->0.
module rr_prio_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       ptr,
  output logic       grant_valid,
  output sel_t       grant_idx
);

  // Scan from lowest priority (offset 4 == ptr) to highest (offset 1) so the
  // last hit, which is the nearest index after ptr, wins.
  always_comb begin
    sel_t idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      idx = ptr + sel_t'(k);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule : rr_prio_pick

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering one of four valid/ready requesters through a
// 4:1 mux into a single registered output stage (1 transfer/cycle).
// Optional feature macro: RR_MUX_ARBITER_LOCK_EN adds in_last and a lock
// state that keeps the grant on one requester until its last beat.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef RR_MUX_ARBITER_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  sel_t             out_sel_q,   out_sel_d;
  sel_t             ptr_q,       ptr_d;

  logic             can_load;
  logic             grant_valid;
  sel_t             grant_idx;
  logic             xfer;
  logic             is_last;
  logic [N-1:0]     req_eff;
  logic [WIDTH-1:0] mux_data;

`ifdef RR_MUX_ARBITER_LOCK_EN
  lock_state_e lock_q, lock_d;
  sel_t        owner_q, owner_d;

  // Lock state register; owner tracks the requester of the latest transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q  <= OPEN;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end

  // Lock next-state: a non-last beat locks, a last beat reopens.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (xfer) begin
      owner_d = grant_idx;
      lock_d  = is_last ? OPEN : LOCKED;
    end
  end

  // Lock outputs: while locked only the owner may be presented to the picker.
  always_comb begin
    req_eff = in_valid;
    if (lock_q == LOCKED) begin
      req_eff = in_valid & (N'(1) << owner_q);
    end
    is_last = in_last[grant_idx];
  end
`else
  // Without locking every transfer is a last beat.
  always_comb begin
    req_eff = in_valid;
    is_last = 1'b1;
  end
`endif

  rr_prio_pick u_pick (
    .req         (req_eff),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Data mux selected by the current grant.
  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == sel_t'(i)) begin
        mux_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Handshake: ready only toward the granted requester when the slot is free.
  always_comb begin
    can_load = ~out_valid_q | out_ready;
    xfer     = rst_n & can_load & grant_valid;
    in_ready = '0;
    if (xfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Output stage next-state: load wins over drain; drain keeps data/sel.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_sel_d   = grant_idx;
      if (is_last) begin
        ptr_d = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output and pointer registers; pointer resets to 3 so requester 0 leads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= 2'd3;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter.
// Lock scenario is compiled in only with RR_MUX_ARBITER_LOCK_EN.
module tb_rr_mux_arbiter;

  localparam int WIDTH = 4;
  localparam int N     = 4;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
`ifdef RR_MUX_ARBITER_LOCK_EN
  logic [N-1:0]       in_last;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  rr_mux_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_MUX_ARBITER_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_sel [5];
  logic [3:0] exp_dat [5];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 16'hDCBA;
    out_ready = 1'b1;
`ifdef RR_MUX_ARBITER_LOCK_EN
    in_last   = 4'b1111;
`endif

    // 1. Reset held 2 cycles with all requesters valid
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_first_grant", 32'(in_ready), 32'b0001);

    // 2. Round robin 0,1,2,3,0
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_dat = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_sel",   32'(out_sel),   32'(exp_sel[i]));
      check("rr_data",  32'(out_data),  32'(exp_dat[i]));
    end

    // 3. Skip idle requesters: only 1 and 3 valid
    do_reset();
    in_valid = 4'b1010;
    #1;
    check("skip_ready", 32'(in_ready), 32'b0010);
    exp_sel = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
    exp_dat = '{4'hB, 4'hD, 4'hB, 4'hD, 4'hB};
    for (int i = 0; i < 4; i++) begin
      step();
      check("skip_sel",  32'(out_sel),  32'(exp_sel[i]));
      check("skip_data", 32'(out_data), 32'(exp_dat[i]));
    end

    // 4. Backpressure after first load
    do_reset();
    in_valid = 4'b1111;
    step();
    check("bp_load_sel", 32'(out_sel), 32'd0);
    out_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_data",     32'(out_data),  32'hA);
      check("bp_sel",      32'(out_sel),   32'd0);
      check("bp_in_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(in_ready), 32'b0010);
    step();
    check("bp_resume_sel",  32'(out_sel),  32'd1);
    check("bp_resume_data", 32'(out_data), 32'hB);
    // Drain with no requesters: valid drops, data/sel held
    in_valid = 4'b0000;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data",  32'(out_data),  32'hB);
    check("drain_sel",   32'(out_sel),   32'd1);

    // 5. Mid-operation reset with data 5 from requester 2
    do_reset();
    in_data  = 16'hD5BA;
    in_valid = 4'b0100;
    step();
    check("mid_sel",  32'(out_sel),  32'd2);
    check("mid_data", 32'(out_data), 32'h5);
    in_valid = 4'b1001;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_next_ready", 32'(in_ready), 32'b0001);
    step();
    check("mid_next_sel", 32'(out_sel), 32'd0);

`ifdef RR_MUX_ARBITER_LOCK_EN
    // 6. Lock: req 2 sends 3 beats (last=0,0,1) while req 0 stays valid
    do_reset();
    in_data  = 16'hDCBA;
    in_valid = 4'b0010;
    in_last  = 4'b1111;
    step();
    check("lock_pre_sel", 32'(out_sel), 32'd1);
    in_valid = 4'b0101;
    in_last  = 4'b1011;
    step();
    check("lock_beat0", 32'(out_sel), 32'd2);
    step();
    check("lock_beat1", 32'(out_sel), 32'd2);
    in_last = 4'b1111;
    step();
    check("lock_beat2", 32'(out_sel), 32'd2);
    step();
    check("lock_after", 32'(out_sel), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rr_mux_arbiter
